// File: rtl/indicator_pkg.sv
// Shared mode/target definitions for the indicator controller.
// Used by indicator_ctrl (optional burst feature: INDICATOR_BURST_EN).
package indicator_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    localparam logic TGT_LED  = 1'b0;
    localparam logic TGT_BEEP = 1'b1;

    // LEDs have no burst behaviour, so BURST degrades to steady ON.
    function automatic mode_e led_mode_of(input logic [1:0] m);
        return (m == MODE_BURST) ? MODE_ON : mode_e'(m);
    endfunction

    function automatic logic on_level(input mode_e m, input logic ph);
        case (m)
            MODE_ON:    return 1'b1;
            MODE_BLINK: return ph;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Half-period counter 0..HALF_CNT-1 with a one-cycle tick on the last count.
// clr restarts the count from zero.
module tick_gen #(
    parameter int HALF_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
    localparam logic [W-1:0] LAST = W'(HALF_CNT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/indicator_ctrl.sv
// LED/beeper indicator controller with shared blink phase.
// Beeper burst sequencing is built only when INDICATOR_BURST_EN is defined.
module indicator_ctrl
    import indicator_pkg::*;
#(
    parameter int LED_NUM  = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BLINK_MS = 250
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    output logic               cmd_ready,
    input  logic               cmd_tgt,
    input  logic [LED_NUM-1:0] cmd_mask,
    input  logic [1:0]         cmd_mode,
    input  logic [7:0]         cmd_arg,
    output logic [LED_NUM-1:0] led,
    output logic               beep_n,
    output logic               burst_done
);

    localparam int HALF_CNT = CLK_FREQ / 1000 * BLINK_MS;

    mode_e led_mode [LED_NUM];
    mode_e beep_mode;
    logic  phase;
    logic  tick;
    logic  accept;

    assign accept = cmd_vld && cmd_ready;

    tick_gen #(
        .HALF_CNT(HALF_CNT)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            led   <= '0;
            for (int i = 0; i < LED_NUM; i++) begin
                led_mode[i] <= MODE_OFF;
            end
        end else begin
            if (tick) begin
                phase <= ~phase;
            end
            for (int i = 0; i < LED_NUM; i++) begin
                led[i] <= on_level(led_mode[i], phase);
                if (accept && cmd_tgt == TGT_LED && cmd_mask[i]) begin
                    led_mode[i] <= led_mode_of(cmd_mode);
                end
            end
        end
    end

`ifdef INDICATOR_BURST_EN

    logic       btick;
    logic       busy;
    logic       son;
    logic [7:0] bcnt;
    logic       is_burst;
    logic       start_burst;
    logic       zero_burst;
    logic       last_pair;

    assign is_burst = accept && cmd_tgt == TGT_BEEP &&
                      cmd_mode == MODE_BURST;
    assign start_burst = is_burst && cmd_arg != 8'd0;
    assign zero_burst  = is_burst && cmd_arg == 8'd0;
    // End of the silent half of the final on/off pair.
    assign last_pair = busy && btick && !son && bcnt <= 8'd1;

    tick_gen #(
        .HALF_CNT(HALF_CNT)
    ) u_burst (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_burst),
        .tick (btick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_mode  <= MODE_OFF;
            beep_n     <= 1'b1;
            burst_done <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            son        <= 1'b0;
            bcnt       <= '0;
        end else begin
            burst_done <= last_pair || zero_burst;
            cmd_ready  <= !(start_burst || (busy && !last_pair));
            if (beep_mode == MODE_BURST) begin
                beep_n <= !son;
            end else begin
                beep_n <= !on_level(beep_mode, phase);
            end
            if (start_burst) begin
                busy      <= 1'b1;
                son       <= 1'b1;
                bcnt      <= cmd_arg;
                beep_mode <= MODE_BURST;
            end else if (zero_burst) begin
                beep_mode <= MODE_OFF;
            end else if (accept && cmd_tgt == TGT_BEEP) begin
                beep_mode <= mode_e'(cmd_mode);
            end else if (busy && btick) begin
                son <= ~son;
                if (!son && bcnt != 8'd0) begin
                    bcnt <= bcnt - 8'd1;
                end
                if (last_pair) begin
                    busy      <= 1'b0;
                    beep_mode <= MODE_OFF;
                end
            end
        end
    end

`else

    logic unused_arg;

    assign unused_arg = ^cmd_arg;
    assign burst_done = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_mode <= MODE_OFF;
            beep_n    <= 1'b1;
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= 1'b1;
            beep_n    <= !on_level(beep_mode, phase);
            if (accept && cmd_tgt == TGT_BEEP) begin
                beep_mode <= led_mode_of(cmd_mode);
            end
        end
    end

`endif

endmodule

// File: tb/tb_indicator_ctrl.sv
// Self-checking bench for indicator_ctrl (HALF_CNT = 4).
// Covers both builds of INDICATOR_BURST_EN.
module tb_indicator_ctrl;

    localparam int H = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_vld = 1'b0;
    logic         cmd_ready;
    logic         cmd_tgt = 1'b0;
    logic [N-1:0] cmd_mask = '0;
    logic [1:0]   cmd_mode = '0;
    logic [7:0]   cmd_arg = '0;
    logic [N-1:0] led;
    logic         beep_n;
    logic         burst_done;

    int total = 0;
    int bad = 0;
    int n_edge;
    int lm [N];
    int bm;

    indicator_ctrl #(
        .LED_NUM  (N),
        .CLK_FREQ (1000),
        .BLINK_MS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_vld    (cmd_vld),
        .cmd_ready  (cmd_ready),
        .cmd_tgt    (cmd_tgt),
        .cmd_mask   (cmd_mask),
        .cmd_mode   (cmd_mode),
        .cmd_arg    (cmd_arg),
        .led        (led),
        .beep_n     (beep_n),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the first edge is 1.
    always @(posedge clk or posedge rst) begin
        if (rst) n_edge <= 0;
        else     n_edge <= n_edge + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output after edge n shows the phase held before that edge.
    function automatic logic blink_now();
        return (((n_edge - 1) / H) % 2) == 1;
    endfunction

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = (lm[i] == 1) || (lm[i] == 2 && blink_now());
        end
        return r;
    endfunction

    function automatic logic exp_beep_n();
        if (bm == 1) return 1'b0;
        if (bm == 2) return !blink_now();
        return 1'b1;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic t, input logic [N-1:0] m,
                         input logic [1:0] md, input logic [7:0] a);
        cmd_tgt  = t;
        cmd_mask = m;
        cmd_mode = md;
        cmd_arg  = a;
        cmd_vld  = 1'b1;
        @(negedge clk);
        cmd_vld  = 1'b0;
    endtask

    task automatic model_cmd(input logic t, input logic [N-1:0] m,
                             input logic [1:0] md);
        int v;
        v = (md == 2'd3) ? 1 : int'(md);
        if (!t) begin
            for (int i = 0; i < N; i++) if (m[i]) lm[i] = v;
        end else begin
            bm = v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       t;
        logic [3:0] m;
        logic [1:0] md;
        logic [7:0] a;
        for (int i = 0; i < N; i++) lm[i] = 0;
        bm = 0;

        repeat (3) cyc();
        chk("rst_led", led, 0);
        chk("rst_beep", beep_n, 1);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", burst_done, 0);
        rst = 1'b0;
        #1 chk("ready_pre_edge", cmd_ready, 0);
        cyc();
        chk("ready_rel", cmd_ready, 1);

        issue(0, 4'b0101, 2'b01, 0);
        chk("on_lat1", led, 4'b0000);
        model_cmd(0, 4'b0101, 2'b01);
        cyc();
        chk("on_lat2", led, 4'b0101);
        issue(0, 4'b0001, 2'b00, 0);
        chk("off_lat1", led, 4'b0101);
        model_cmd(0, 4'b0001, 2'b00);
        cyc();
        chk("off_lat2", led, 4'b0100);

        issue(0, 4'b1111, 2'b10, 0);
        model_cmd(0, 4'b1111, 2'b10);
        repeat (16) begin
            cyc();
            chk("blink", led, exp_led());
        end

        repeat (24) begin
            t  = 1'($urandom_range(0, 1));
            m  = 4'($urandom);
            md = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
`ifdef INDICATOR_BURST_EN
            if (t && md == 2'd3) md = 2'd1;
`endif
            chk("rnd_ready", cmd_ready, 1);
            issue(t, m, md, a);
            model_cmd(t, m, md);
            repeat ($urandom_range(1, 6)) begin
                cyc();
                chk("rnd_led", led, exp_led());
                chk("rnd_beep", beep_n, exp_beep_n());
            end
        end

        issue(0, 4'b1111, 2'b00, 0);
        model_cmd(0, 4'b1111, 2'b00);
        issue(1, 0, 2'b00, 0);
        model_cmd(1, 0, 2'b00);
        cyc();
        cyc();

`ifdef INDICATOR_BURST_EN
        begin
            int lows;
            int dones;
            lows = 0;
            dones = 0;
            issue(1, 0, 2'b11, 8'd3);
            cmd_tgt  = 1'b0;
            cmd_mask = 4'b1000;
            cmd_mode = 2'b01;
            cmd_vld  = 1'b1;
            for (int k = 0; k <= 27; k++) begin
                if (k > 0) cyc();
                chk("burst_beep", beep_n,
                    (k >= 1 && k <= 24) ? (((k - 1) / H) % 2 == 1) : 1'b1);
                chk("burst_ready", cmd_ready, k >= 24);
                chk("burst_done", burst_done, k == 24);
                chk("held_cmd_led", led, (k >= 26) ? 4'b1000 : 4'b0000);
                lows += int'(!beep_n);
                dones += int'(burst_done);
                if (k == 25) cmd_vld = 1'b0;
            end
            chk("burst_low_cycles", lows, 12);
            chk("burst_done_count", dones, 1);
        end

        issue(1, 0, 2'b11, 8'd0);
        chk("zero_done", burst_done, 1);
        chk("zero_ready", cmd_ready, 1);
        chk("zero_beep0", beep_n, 1);
        cyc();
        chk("zero_done_end", burst_done, 0);
        chk("zero_beep1", beep_n, 1);

        issue(0, 4'b1111, 2'b01, 0);
        issue(1, 0, 2'b11, 8'd2);
        repeat (5) cyc();
        chk("mid_led", led, 4'b1111);
        chk("mid_ready", cmd_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", led, 0);
        chk("arst_beep", beep_n, 1);
        chk("arst_ready", cmd_ready, 0);
        repeat (3) begin
            cyc();
            chk("arst_done", burst_done, 0);
        end
        rst = 1'b0;
        cyc();
        chk("arst_ready_rel", cmd_ready, 1);
        repeat (20) begin
            cyc();
            chk("arst_no_done", burst_done, 0);
            chk("arst_beep_off", beep_n, 1);
        end
`else
        issue(1, 0, 2'b11, 8'd3);
        cyc();
        chk("noburst_beep", beep_n, 0);
        repeat (20) begin
            cyc();
            chk("noburst_beep", beep_n, 0);
            chk("noburst_done", burst_done, 0);
            chk("noburst_ready", cmd_ready, 1);
        end

        issue(0, 4'b1111, 2'b01, 0);
        cyc();
        chk("mid_led", led, 4'b1111);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", led, 0);
        chk("arst_beep", beep_n, 1);
        chk("arst_ready", cmd_ready, 0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("arst_ready_rel", cmd_ready, 1);
        chk("arst_led_rel", led, 0);
        chk("arst_beep_rel", beep_n, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
